// File: rtl/dispatch_sched_if.sv
// Dispatch handshake bundle: rename slots in, ROB / int issue queue / busy
// table out, plus flush and the stall counter observation port.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE 2'b00
`endif

interface dispatch_sched_if #(
  parameter int PAYLOAD_WIDTH = 241,
  parameter int ROBID_WIDTH   = 7,
  parameter int DATA_WIDTH    = 248
);
  logic                     pipe2disp_instr0_valid;
  logic                     pipe2disp_instr1_valid;
  logic                     disp2pipe_instr0_ready;
  logic                     disp2pipe_instr1_ready;
  logic [PAYLOAD_WIDTH-1:0] instr0_payload;
  logic [PAYLOAD_WIDTH-1:0] instr1_payload;
  logic [5:0]               instr0_prd;
  logic [5:0]               instr1_prd;
  logic                     instr0_need_to_wb;
  logic                     instr1_need_to_wb;
  logic                     rob_can_enq;
  logic                     rob_can_enq2;
  logic [1:0]               rob_state;
  logic [ROBID_WIDTH-1:0]   rob2disp_instr_robid;
  logic                     disp2rob_instr0_enq_valid;
  logic                     disp2rob_instr1_enq_valid;
  logic [PAYLOAD_WIDTH-1:0] disp2rob_instr0_payload;
  logic [PAYLOAD_WIDTH-1:0] disp2rob_instr1_payload;
  logic                     intisq_can_enq;
  logic                     disp2intisq_enq_valid;
  logic [DATA_WIDTH-1:0]    disp2intisq_instr0_enq_data;
  logic                     disp2bt_alloc_instr0rd_en;
  logic                     disp2bt_alloc_instr1rd_en;
  logic [5:0]               disp2bt_alloc_instr0rd_addr;
  logic [5:0]               disp2bt_alloc_instr1rd_addr;
  logic                     flush_valid;
  logic [31:0]              disp_stall_cnt;

  // Dispatch side
  modport slave (
    input  pipe2disp_instr0_valid, pipe2disp_instr1_valid,
    input  instr0_payload, instr1_payload, instr0_prd, instr1_prd,
    input  instr0_need_to_wb, instr1_need_to_wb,
    input  rob_can_enq, rob_can_enq2, rob_state, rob2disp_instr_robid,
    input  intisq_can_enq, flush_valid,
    output disp2pipe_instr0_ready, disp2pipe_instr1_ready,
    output disp2rob_instr0_enq_valid, disp2rob_instr1_enq_valid,
    output disp2rob_instr0_payload, disp2rob_instr1_payload,
    output disp2intisq_enq_valid, disp2intisq_instr0_enq_data,
    output disp2bt_alloc_instr0rd_en, disp2bt_alloc_instr1rd_en,
    output disp2bt_alloc_instr0rd_addr, disp2bt_alloc_instr1rd_addr,
    output disp_stall_cnt
  );

  // Rename / backend environment side
  modport master (
    output pipe2disp_instr0_valid, pipe2disp_instr1_valid,
    output instr0_payload, instr1_payload, instr0_prd, instr1_prd,
    output instr0_need_to_wb, instr1_need_to_wb,
    output rob_can_enq, rob_can_enq2, rob_state, rob2disp_instr_robid,
    output intisq_can_enq, flush_valid,
    input  disp2pipe_instr0_ready, disp2pipe_instr1_ready,
    input  disp2rob_instr0_enq_valid, disp2rob_instr1_enq_valid,
    input  disp2rob_instr0_payload, disp2rob_instr1_payload,
    input  disp2intisq_enq_valid, disp2intisq_instr0_enq_data,
    input  disp2bt_alloc_instr0rd_en, disp2bt_alloc_instr1rd_en,
    input  disp2bt_alloc_instr0rd_addr, disp2bt_alloc_instr1rd_addr,
    input  disp_stall_cnt
  );
endinterface

// File: rtl/dispatch_sched.sv
// Dual-slot dispatch sequencer: both instructions enter the ROB together,
// slot1 is parked in a one-entry hold register and reaches the single-port
// integer issue queue one cycle (or more, under backpressure) later.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE 2'b00
`endif

module dispatch_sched #(
  parameter int PAYLOAD_WIDTH = 241,
  parameter int ROBID_WIDTH   = 7,
  parameter int DATA_WIDTH    = 248
) (
  input  logic            clock,
  input  logic            reset_n,  // active-high synchronous reset
  dispatch_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic                   ok;
  logic                   rob_idle;
  logic                   ready0, ready1, fire0, fire1;
  logic [ROBID_WIDTH-1:0] robid_next;

  assign rob_idle   = (bus.rob_state == `ROB_STATE_IDLE);
  assign ok         = bus.rob_can_enq & bus.intisq_can_enq & rob_idle & ~bus.flush_valid;
  assign robid_next = bus.rob2disp_instr_robid + 1'b1;

  // Output decode and next-state; flush overrides everything, reset silences outputs
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    fire0        = 1'b0;
    fire1        = 1'b0;
    bus.disp2rob_instr0_enq_valid   = 1'b0;
    bus.disp2rob_instr1_enq_valid   = 1'b0;
    bus.disp2rob_instr0_payload     = bus.instr0_payload;
    bus.disp2rob_instr1_payload     = bus.instr1_payload;
    bus.disp2intisq_enq_valid       = 1'b0;
    bus.disp2intisq_instr0_enq_data = {bus.rob2disp_instr_robid, bus.instr0_payload};
    bus.disp2bt_alloc_instr0rd_en   = 1'b0;
    bus.disp2bt_alloc_instr1rd_en   = 1'b0;
    bus.disp2bt_alloc_instr0rd_addr = bus.instr0_prd;
    bus.disp2bt_alloc_instr1rd_addr = bus.instr1_prd;
    if (!reset_n) begin
      if (bus.flush_valid) begin
        hold_valid_d = 1'b0;
        state_d      = S_FLUSH;
      end else begin
        case (state_q)
          S_IDLE: begin
            ready0 = ok;
            ready1 = ok & bus.rob_can_enq2;
            fire0  = bus.pipe2disp_instr0_valid & ready0;
            fire1  = fire0 & bus.pipe2disp_instr1_valid & ready1;
            bus.disp2rob_instr0_enq_valid = fire0;
            bus.disp2intisq_enq_valid     = fire0;
            bus.disp2bt_alloc_instr0rd_en = fire0 & bus.instr0_need_to_wb;
            bus.disp2rob_instr1_enq_valid = fire1;
            bus.disp2bt_alloc_instr1rd_en = fire1 & bus.instr1_need_to_wb;
            if (fire1) begin
              // slot1 takes the id after slot0, wrapping at the pointer width
              hold_data_d  = {robid_next, bus.instr1_payload};
              hold_valid_d = 1'b1;
              state_d      = S_HOLD;
            end
          end
          S_HOLD: begin
            bus.disp2intisq_enq_valid       = hold_valid_q & bus.intisq_can_enq;
            bus.disp2intisq_instr0_enq_data = hold_data_q;
            if (hold_valid_q & bus.intisq_can_enq) begin
              hold_valid_d = 1'b0;
              state_d      = S_IDLE;
            end
          end
          S_FLUSH: begin
            if (rob_idle) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign bus.disp2pipe_instr0_ready = ready0;
  assign bus.disp2pipe_instr1_ready = ready1;
  assign bus.disp_stall_cnt         = stall_cnt_q;

  // Stall counter: counts cycles slot0 is offered but refused, saturating
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.pipe2disp_instr0_valid & ~ready0 & (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Control state: FSM, hold-valid flag and stall counter
  always_ff @(posedge clock) begin
    if (reset_n) begin
      state_q      <= S_IDLE;
      hold_valid_q <= 1'b0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Hold data is qualified by hold_valid_q, so it needs no reset
  always_ff @(posedge clock) begin
    hold_data_q <= hold_data_d;
  end
endmodule

// File: tb/tb_dispatch_sched.sv
// Directed bench for dispatch_sched: single/pair dispatch, robid wrap under
// issue-queue backpressure, ROB two-slot shortage, flush recovery, reset mid-hold.
`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE 2'b00
`endif

module tb_dispatch_sched;
  localparam int PW = 241;
  localparam int RW = 7;
  localparam int DW = 248;

  logic clock = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  logic [PW-1:0] p0, p1;

  dispatch_sched_if #(.PAYLOAD_WIDTH(PW), .ROBID_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

  dispatch_sched #(.PAYLOAD_WIDTH(PW), .ROBID_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic defaults();
    bus.pipe2disp_instr0_valid = 1'b0;
    bus.pipe2disp_instr1_valid = 1'b0;
    bus.instr0_payload    = p0;
    bus.instr1_payload    = p1;
    bus.instr0_prd        = 6'd0;
    bus.instr1_prd        = 6'd0;
    bus.instr0_need_to_wb = 1'b0;
    bus.instr1_need_to_wb = 1'b0;
    bus.rob_can_enq       = 1'b1;
    bus.rob_can_enq2      = 1'b1;
    bus.rob_state         = `ROB_STATE_IDLE;
    bus.rob2disp_instr_robid = '0;
    bus.intisq_can_enq    = 1'b1;
    bus.flush_valid       = 1'b0;
  endtask

  // Drive at the falling edge; combinational outputs are checked 1ns later
  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_pair(input logic [RW-1:0] id);
    bus.pipe2disp_instr0_valid = 1'b1;
    bus.pipe2disp_instr1_valid = 1'b1;
    bus.instr0_payload = p0;
    bus.instr1_payload = p1;
    bus.rob2disp_instr_robid = id;
  endtask

  initial begin
    p0 = PW'(64'hA0A0_0000_0000_0001);
    p1 = PW'(64'hB0B0_0000_0000_0002);
    reset_n = 1'b1;
    defaults();
    bus.pipe2disp_instr0_valid = 1'b1;
    step(); step(); settle();
    // Reset: nothing asserted even with a valid slot0 offered
    chk("rst_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    chk("rst_rob_enq0", bus.disp2rob_instr0_enq_valid, 1'b0);
    chk("rst_isq_enq", bus.disp2intisq_enq_valid, 1'b0);
    chk("rst_stall", bus.disp_stall_cnt, 32'd0);

    // Test 1: single instruction
    step(); reset_n = 1'b0; defaults();
    bus.pipe2disp_instr0_valid = 1'b1;
    bus.rob2disp_instr_robid = 7'd5;
    bus.instr0_need_to_wb = 1'b1;
    bus.instr0_prd = 6'd12;
    settle();
    chk("t1_ready0", bus.disp2pipe_instr0_ready, 1'b1);
    chk("t1_rob_enq0", bus.disp2rob_instr0_enq_valid, 1'b1);
    chk("t1_rob_enq1", bus.disp2rob_instr1_enq_valid, 1'b0);
    chk("t1_rob_pay0", bus.disp2rob_instr0_payload, p0);
    chk("t1_isq_vld", bus.disp2intisq_enq_valid, 1'b1);
    chk("t1_isq_data", bus.disp2intisq_instr0_enq_data, {7'd5, p0});
    chk("t1_bt0_en", bus.disp2bt_alloc_instr0rd_en, 1'b1);
    chk("t1_bt0_addr", bus.disp2bt_alloc_instr0rd_addr, 6'd12);
    step(); defaults(); settle();
    chk("t1_still_idle", bus.disp2pipe_instr0_ready, 1'b1);
    chk("t1_no_isq", bus.disp2intisq_enq_valid, 1'b0);

    // Test 2: pair
    step(); defaults(); drive_pair(7'd9);
    bus.instr1_need_to_wb = 1'b1;
    bus.instr1_prd = 6'd20;
    settle();
    chk("t2_ready1", bus.disp2pipe_instr1_ready, 1'b1);
    chk("t2_rob_enq0", bus.disp2rob_instr0_enq_valid, 1'b1);
    chk("t2_rob_enq1", bus.disp2rob_instr1_enq_valid, 1'b1);
    chk("t2_rob_pay1", bus.disp2rob_instr1_payload, p1);
    chk("t2_isq_data0", bus.disp2intisq_instr0_enq_data, {7'd9, p0});
    chk("t2_bt1_en", bus.disp2bt_alloc_instr1rd_en, 1'b1);
    chk("t2_bt1_addr", bus.disp2bt_alloc_instr1rd_addr, 6'd20);
    step(); defaults(); settle();
    chk("t2_hold_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    chk("t2_hold_ready1", bus.disp2pipe_instr1_ready, 1'b0);
    chk("t2_hold_isq_vld", bus.disp2intisq_enq_valid, 1'b1);
    chk("t2_hold_isq_data", bus.disp2intisq_instr0_enq_data, {7'd10, p1});
    chk("t2_hold_no_rob", bus.disp2rob_instr0_enq_valid, 1'b0);
    step(); defaults(); settle();
    chk("t2_back_idle", bus.disp2pipe_instr0_ready, 1'b1);

    // Test 3: robid wrap with issue-queue backpressure
    step(); defaults(); drive_pair(7'd127); settle();
    chk("t3_fire_enq1", bus.disp2rob_instr1_enq_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); defaults();
      bus.pipe2disp_instr0_valid = 1'b1;
      bus.intisq_can_enq = 1'b0;
      settle();
      chk("t3_bp_isq_vld", bus.disp2intisq_enq_valid, 1'b0);
      chk("t3_bp_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    end
    step(); defaults(); bus.pipe2disp_instr0_valid = 1'b1; settle();
    chk("t3_drain_vld", bus.disp2intisq_enq_valid, 1'b1);
    chk("t3_drain_data", bus.disp2intisq_instr0_enq_data, {7'd0, p1});
    chk("t3_drain_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    step(); defaults(); settle();
    chk("t3_stall_cnt", bus.disp_stall_cnt, 32'd4);
    chk("t3_back_idle", bus.disp2pipe_instr0_ready, 1'b1);

    // Test 4: ROB has room for only one
    step(); defaults(); drive_pair(7'd20); bus.rob_can_enq2 = 1'b0; settle();
    chk("t4_ready0", bus.disp2pipe_instr0_ready, 1'b1);
    chk("t4_ready1", bus.disp2pipe_instr1_ready, 1'b0);
    chk("t4_rob_enq1", bus.disp2rob_instr1_enq_valid, 1'b0);
    chk("t4_isq_data", bus.disp2intisq_instr0_enq_data, {7'd20, p0});
    step(); defaults();
    bus.pipe2disp_instr0_valid = 1'b1;
    bus.instr0_payload = p1;
    bus.rob2disp_instr_robid = 7'd21;
    settle();
    chk("t4_shift_enq0", bus.disp2rob_instr0_enq_valid, 1'b1);
    chk("t4_shift_data", bus.disp2intisq_instr0_enq_data, {7'd21, p1});

    // Test 5: flush during HOLD, ROB state walk
    step(); defaults(); drive_pair(7'd30); settle();
    step(); defaults(); bus.flush_valid = 1'b1; settle();
    chk("t5_flush_isq", bus.disp2intisq_enq_valid, 1'b0);
    chk("t5_flush_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); defaults(); bus.rob_state = 2'd1; settle();
      chk("t5_walk_ready0", bus.disp2pipe_instr0_ready, 1'b0);
      chk("t5_walk_isq", bus.disp2intisq_enq_valid, 1'b0);
    end
    step(); defaults(); settle();
    chk("t5_last_flush_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    step(); defaults(); settle();
    chk("t5_recover_ready0", bus.disp2pipe_instr0_ready, 1'b1);
    chk("t5_hold_dropped", bus.disp2intisq_enq_valid, 1'b0);

    // Flush beats a simultaneous rename valid in IDLE
    step(); defaults();
    bus.pipe2disp_instr0_valid = 1'b1;
    bus.instr0_need_to_wb = 1'b1;
    bus.flush_valid = 1'b1;
    settle();
    chk("fl_rob_enq0", bus.disp2rob_instr0_enq_valid, 1'b0);
    chk("fl_bt0_en", bus.disp2bt_alloc_instr0rd_en, 1'b0);
    chk("fl_isq", bus.disp2intisq_enq_valid, 1'b0);
    step(); defaults(); settle();
    step(); defaults(); settle();
    chk("fl_stall_cnt", bus.disp_stall_cnt, 32'd5);
    chk("fl_recover", bus.disp2pipe_instr0_ready, 1'b1);

    // Test 6: reset mid-HOLD
    step(); defaults(); drive_pair(7'd40); settle();
    step(); defaults(); reset_n = 1'b1; bus.pipe2disp_instr0_valid = 1'b1; settle();
    chk("t6_rst_isq", bus.disp2intisq_enq_valid, 1'b0);
    chk("t6_rst_ready0", bus.disp2pipe_instr0_ready, 1'b0);
    step(); defaults(); reset_n = 1'b0; settle();
    chk("t6_idle_ready0", bus.disp2pipe_instr0_ready, 1'b1);
    chk("t6_hold_cleared", bus.disp2intisq_enq_valid, 1'b0);
    chk("t6_stall_zero", bus.disp_stall_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
